sram_responder: RTL and testbench

- Synthesizable stand-in for the external 8-bit asynchronous SRAM, built on on-chip block RAM.
- Answers the async-SRAM pin protocol (address, bidirectional data, active-low write strobe) driven by an on-board initiator such as the RAM self-test engine.
- Lets that initiator run on boards with no SRAM fitted, or in simulation.
- Runs in the initiator's clock domain; adds a power-on clear, fault injection for exercising failure paths, and write statistics.

---
 rtl/sram_responder_pkg.sv | 19 +
 rtl/sram_responder_mem.sv | 23 ++
 rtl/sram_responder.sv | 87 ++++++++
 tb/tb_sram_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared state encoding, counter width and read-fault helper.
package sram_responder_pkg;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    localparam int WR_COUNT_W = 20;

    function automatic logic [7:0] fault_apply(
        input logic [7:0]  data,
        input logic [31:0] addr,
        input logic        en,
        input logic [31:0] faddr,
        input logic [7:0]  mask
    );
        return (en && addr == faddr) ? data ^ mask : data;
    endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// sram_responder_mem: single-port synchronous byte RAM, write-first, registered read.
module sram_responder_mem #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: block-RAM stand-in for an 8-bit async SRAM with power-on clear,
// read-fault injection and write statistics, clocked by the initiator's clock.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int         AW       = 19,
    parameter int         MEM_AW   = 12,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         sram_a,
    inout  wire  [7:0]            sram_d,
    input  logic                  sram_we_n,
    input  logic                  sram_oe_n,
    input  logic                  fault_en,
    input  logic [MEM_AW-1:0]     fault_addr,
    input  logic [7:0]            fault_mask,
    output logic                  ready,
    output logic [WR_COUNT_W-1:0] wr_count,
    output logic                  alias_hit,
    output logic                  drop_hit
);

    logic [0:0]            state_q, state_d;
    logic [MEM_AW-1:0]     clr_q, clr_d;
    logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
    logic                  alias_q, alias_d;
    logic                  drop_q, drop_d;
    logic [7:0]            fmask_q, fmask_d;
    logic                  rdv_q;
    logic                  clearing, wr, mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [7:0]            mem_wdata, mem_rdata, rd;

    always_comb begin
        clearing   = state_q == CLEAR;
        wr         = !clearing && !sram_we_n;
        state_d    = (clearing && clr_q == '1) ? RUN : state_q;
        clr_d      = clearing ? clr_q + 1'b1 : clr_q;
        wr_count_d = (wr && wr_count_q != '1) ? wr_count_q + 1'b1 : wr_count_q;
        alias_d    = alias_q | (wr && |sram_a[AW-1:MEM_AW]);
        drop_d     = drop_q | (clearing && !sram_we_n);
        mem_we     = clearing || wr;
        mem_addr   = clearing ? clr_q : sram_a[MEM_AW-1:0];
        mem_wdata  = clearing ? INIT_VAL : sram_d;
        // The fault XOR is captured alongside the read so it lines up with the registered RAM output.
        fmask_d    = fault_apply(8'h00, 32'(sram_a[MEM_AW-1:0]), fault_en, 32'(fault_addr), fault_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_q      <= '0;
            wr_count_q <= '0;
            alias_q    <= 1'b0;
            drop_q     <= 1'b0;
            fmask_q    <= '0;
            rdv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            wr_count_q <= wr_count_d;
            alias_q    <= alias_d;
            drop_q     <= drop_d;
            fmask_q    <= fmask_d;
            rdv_q      <= 1'b1;
        end
    end

    sram_responder_mem #(.MEM_AW(MEM_AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rd        = rdv_q ? mem_rdata ^ fmask_q : 8'h00;
    assign ready     = state_q == RUN;
    assign wr_count  = wr_count_q;
    assign alias_hit = alias_q;
    assign drop_hit  = drop_q;
    // Enable is purely combinational from the pins so the bus frees the same cycle the strobe falls.
    assign sram_d    = (ready && sram_we_n && !sram_oe_n) ? rd : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized and directed checks of sram_responder against a byte-array model.
module tb_sram_responder;

    localparam int AW     = 19;
    localparam int MEM_AW = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     sram_a = '0;
    wire  [7:0]        sram_d;
    logic              sram_we_n = 1'b1;
    logic              sram_oe_n = 1'b0;
    logic              fault_en = 1'b0;
    logic [MEM_AW-1:0] fault_addr = '0;
    logic [7:0]        fault_mask = '0;
    logic              ready;
    logic [19:0]       wr_count;
    logic              alias_hit;
    logic              drop_hit;
    logic [7:0]        tb_d = '0;
    logic              tb_drv = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] rd_m;
    bit         rd_ok, ready_m, alias_m, drop_m;
    int         clr_m, wrc_m;

    assign sram_d = tb_drv ? tb_d : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (sram_d[g]);
    end

    always #5 clk = ~clk;

    sram_responder #(.AW(AW), .MEM_AW(MEM_AW), .INIT_VAL(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .fault_en   (fault_en),
        .fault_addr (fault_addr),
        .fault_mask (fault_mask),
        .ready      (ready),
        .wr_count   (wr_count),
        .alias_hit  (alias_hit),
        .drop_hit   (drop_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ready_m = 0;
        clr_m   = 0;
        wrc_m   = 0;
        alias_m = 0;
        drop_m  = 0;
        rd_ok   = 0;
    endtask

    task automatic model_edge();
        int a;
        a = int'(sram_a[MEM_AW-1:0]);
        if (rst) begin
            model_reset();
        end else if (!ready_m) begin
            if (!sram_we_n) drop_m = 1;
            clr_m++;
            rd_ok = 0;
            if (clr_m == DEPTH) begin
                ready_m = 1;
                foreach (mem_m[i]) mem_m[i] = 8'h00;
            end
        end else begin
            if (!sram_we_n) begin
                mem_m[a] = tb_drv ? tb_d : 8'hFF;
                if (wrc_m < 'hFFFFF) wrc_m++;
                if (sram_a >= AW'(DEPTH)) alias_m = 1;
            end
            rd_m  = mem_m[a] ^ ((fault_en && a == int'(fault_addr)) ? fault_mask : 8'h00);
            rd_ok = 1;
        end
    endtask

    task automatic compare();
        bit drive;
        drive = ready_m && sram_we_n && !sram_oe_n;
        check("ready", 32'(ready), 32'(ready_m));
        check("wr_count", 32'(wr_count), 32'(wrc_m));
        check("alias_hit", 32'(alias_hit), 32'(alias_m));
        check("drop_hit", 32'(drop_hit), 32'(drop_m));
        if (!tb_drv && !(drive && !rd_ok))
            check("bus", 32'(sram_d), drive ? 32'(rd_m) : 32'hFF);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input int hold);
        sram_a = a;
        tb_d = d;
        tb_drv = 1'b1;
        sram_we_n = 1'b0;
        repeat (hold) step();
        sram_we_n = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input int hold, output logic [7:0] d);
        sram_a = a;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b0;
        repeat (hold) step();
        d = sram_d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp);
        int n;
        n = 0;
        while (!ready && n < 64) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic selftest(input int hold);
        logic [7:0] d;
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'h55, hold);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), hold, d);
            wr(AW'(i), d + 8'h55, hold);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), hold, d);
            check($sformatf("selftest_h%0d_a%0d", hold, i), 32'(d), 32'hAA);
        end
    endtask

    initial begin
        logic [7:0] d;
        model_reset();
        @(negedge clk);
        do_reset();
        wait_ready("clear_len", DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), 1, d);
            check("init_read", 32'(d), 32'h00);
        end

        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'h55, 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), 1, d);
            check("rd55", 32'(d), 32'h55);
        end
        check("wrc16", 32'(wr_count), 32'd16);
        check("alias0", 32'(alias_hit), 32'd0);

        wr(AW'(7), 8'hAA, 1);
        fault_en = 1'b1;
        fault_addr = 4'h7;
        fault_mask = 8'h01;
        rd(AW'(7), 1, d);
        check("fault7", 32'(d), 32'hAB);
        rd(AW'(6), 1, d);
        check("fault6", 32'(d), 32'h55);
        fault_en = 1'b0;
        rd(AW'(7), 1, d);
        check("nofault7", 32'(d), 32'hAA);

        wr(19'h00013, 8'h3C, 1);
        rd(AW'(3), 1, d);
        check("alias_data", 32'(d), 32'h3C);
        check("alias1", 32'(alias_hit), 32'd1);

        selftest(1);
        selftest(4);

        for (int i = 0; i < 2000; i++) begin
            sram_a = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) sram_a[AW-1:MEM_AW] = (AW-MEM_AW)'($urandom);
            sram_we_n = $urandom_range(0, 2) != 0;
            tb_drv = !sram_we_n;
            tb_d = 8'($urandom);
            sram_oe_n = $urandom_range(0, 5) == 0;
            fault_en = $urandom_range(0, 3) == 0;
            fault_addr = MEM_AW'($urandom);
            fault_mask = 8'($urandom);
            step();
        end
        sram_we_n = 1'b1;
        tb_drv = 1'b0;
        sram_oe_n = 1'b0;
        fault_en = 1'b0;
        step();

        wr(AW'(2), 8'h11, 1);
        sram_a = AW'(5);
        tb_d = 8'h99;
        tb_drv = 1'b1;
        sram_we_n = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("rst_wrc", 32'(wr_count), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_alias", 32'(alias_hit), 32'd0);
        tb_drv = 1'b0;
        sram_we_n = 1'b1;
        #1 check("rst_bus", 32'(sram_d), 32'hFF);
        repeat (2) step();
        rst = 1'b0;
        wait_ready("clear_len2", DEPTH);

        do_reset();
        repeat (3) step();
        tb_drv = 1'b1;
        tb_d = 8'h77;
        sram_we_n = 1'b0;
        step();
        sram_we_n = 1'b1;
        tb_drv = 1'b0;
        check("drop1", 32'(drop_hit), 32'd1);
        wait_ready("clear_len_drop", DEPTH - 4);
        check("drop_wrc", 32'(wr_count), 32'd0);

        do_reset();
        repeat (9) step();
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        wait_ready("clear_restart", DEPTH);
        rd(AW'(9), 1, d);
        check("restart_read", 32'(d), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
